cordic_angle_sequencer: RTL
===========================

# cordic_angle_sequencer

Consumes the CORDIC arctangent ROM, the 32-entry `atan(2^-i)` single-precision table. On `start` it reads table entries 0..`n_iter` in order and presents each angle to the CORDIC iteration datapath over a valid/ready handshake. It tags each angle with its iteration index and a last flag, and pulses `done` after the final angle is accepted. It sits between the coprocessor control FSM, the angle ROM (1-cycle registered read that outputs zero when disabled) and the Z-path adder.

## Interface
Parameters:
- `W`, 32, angle word width; must match the ROM data width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a sequence; sampled only in IDLE, ignored otherwise.
- `n_iter`  in  5  index of the last entry to deliver (entries delivered = `n_iter`+1); latched on accepted `start`.
- `rom_enable`  out  1  registered ROM read enable.
- `rom_address`  out  5  registered ROM address.
- `rom_data`  in  W  ROM read data, valid the cycle after `rom_enable`=1.
- `angle_valid`  out  1  `angle_data`/`angle_index`/`angle_last` are valid.
- `angle_ready`  in  1  datapath accepts the angle when high with `angle_valid`.
- `angle_data`  out  W  arctangent word, IEEE-754 single.
- `angle_index`  out  5  iteration index of `angle_data`.
- `angle_last`  out  1  high when `angle_index` == latched `n_iter`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse, the cycle after the last handshake.

## Operation
- Reset (`rst`=0): state IDLE. All outputs are 0, and the index, latched `n_iter` and buffer registers are cleared. Reset mid-sequence aborts the sequence with no `done` pulse.
- States and transitions:
  - IDLE: on `start`, go to REQ. Set `rom_enable`<=1, `rom_address`<=0, idx<=0, last_idx<=`n_iter`, `busy`<=1.
  - REQ: ROM read in flight. Set `rom_enable`<=0 and go to CAP.
  - CAP: capture `rom_data` into `angle_data`. Set `angle_index`<=idx, `angle_last`<=(idx==last_idx), `angle_valid`<=1, and go to OFFER.
  - OFFER: hold all angle outputs stable until `angle_valid`&`angle_ready`.
    - On handshake with `angle_last`=1: `angle_valid`<=0, `done`<=1, go to DONE.
    - Otherwise: idx<=idx+1, `rom_enable`<=1, `rom_address`<=idx+1, `angle_valid`<=0, go to REQ.
  - DONE: `done`<=0, `busy`<=0, go to IDLE.
- `angle_data` is never taken from `rom_data` in a cycle when `rom_enable` was 0, because the ROM outputs zero in that cycle.
- Index arithmetic is 5-bit. idx is never incremented past last_idx, so `n_iter`=31 ends at index 31 without wrap.
- `n_iter`=0 delivers exactly one angle, with `angle_last`=1.
- `start` asserted in any state other than IDLE is ignored. A change on `n_iter` after latch has no effect.
- `angle_ready` without `angle_valid` has no effect.

## Timing
- `start` accepted in cycle t:
  - `rom_enable`=1 in t+1.
  - `rom_data` is valid and captured at the end of t+2.
  - `angle_valid`=1 in t+3.
- Handshake in cycle h (not last): next `angle_valid`=1 in h+3. The minimum period is 3 cycles per angle.
- Last handshake in cycle h: `done`=1 in h+1 and `busy`=0 in h+2. A new `start` is accepted in IDLE from h+2.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `CORDIC_ANGLE_PREFETCH_EN` defined:
  - REQ/CAP/OFFER are replaced by a 2-entry angle FIFO.
  - A ROM read is issued every cycle while (entries + reads in flight) < 2 and unread indices remain.
  - With `angle_ready` held high, angles are delivered on consecutive cycles after the initial 3-cycle latency.
  - Ordering, `angle_last`, `done` (the cycle after the last handshake), reset and `start`-ignore rules are unchanged.
- `CORDIC_ANGLE_PREFETCH_EN` not defined: the 3-cycle-per-angle FSM above applies.

## Test plan
- Reset, then release with `start`=0 -> all outputs 0; `rom_enable` stays 0 for 10 cycles.
- `start`, `n_iter`=3, `angle_ready`=1 -> outputs are 3f490fdb/idx0, 3eed6338/idx1, 3e7adbb0/idx2, 3dfeadd5/idx3 with `angle_last`=1 on idx3 only. First valid is at start+3 and the spacing is 3 cycles (1 with prefetch). `done` pulses once.
- `n_iter`=31, `angle_ready` toggled pseudo-randomly -> 32 angles in order. Index 12 is 39800000 and index 31 is 30000000. Outputs are stable while stalled.
- `n_iter`=0 -> single angle 3f490fdb with `angle_last`=1. `done` is at handshake+1 and `busy` falls at handshake+2.
- `start` pulsed while busy, and `n_iter` changed mid-sequence -> sequence is unaffected; no restart.
- `rst` asserted while in OFFER at idx 5 -> next cycle all outputs are 0 with no `done`. A subsequent `start` restarts from idx 0.

Source files
------------

// File: rtl/cordic_angle_sequencer.sv
// Streams atan(2^-i) ROM entries 0..n_iter to the CORDIC Z-path over valid/ready.
// Define CORDIC_ANGLE_PREFETCH_EN for the prefetching FIFO variant.
module cordic_angle_sequencer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   n_iter,
  output logic         rom_enable,
  output logic [4:0]   rom_address,
  input  logic [W-1:0] rom_data,
  output logic         angle_valid,
  input  logic         angle_ready,
  output logic [W-1:0] angle_data,
  output logic [4:0]   angle_index,
  output logic         angle_last,
  output logic         busy,
  output logic         done
);

`ifdef CORDIC_ANGLE_PREFETCH_EN

  typedef enum logic [1:0] {
    P_IDLE,
    P_RUN,
    P_DONE
  } state_e;

  state_e       state_q, state_d;
  logic         rom_enable_q, rom_enable_d;
  logic [4:0]   rom_address_q, rom_address_d;
  logic [4:0]   next_idx_q, next_idx_d;
  logic         issued_all_q, issued_all_d;
  logic         pend_q, pend_d;
  logic [4:0]   pend_idx_q, pend_idx_d;
  logic [4:0]   last_idx_q, last_idx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;
  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] data_q [3];
  logic [W-1:0] data_d [3];
  logic [4:0]   tag_q [3];
  logic [4:0]   tag_d [3];
  logic         lst_q [3];
  logic         lst_d [3];
  logic         pop;
  logic [1:0]   occ_t;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= P_IDLE;
      rom_enable_q  <= 1'b0;
      rom_address_q <= '0;
      next_idx_q    <= '0;
      issued_all_q  <= 1'b0;
      pend_q        <= 1'b0;
      pend_idx_q    <= '0;
      last_idx_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      valid_q       <= 1'b0;
      occ_q         <= '0;
      for (int i = 0; i < 3; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        lst_q[i]  <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      rom_enable_q  <= rom_enable_d;
      rom_address_q <= rom_address_d;
      next_idx_q    <= next_idx_d;
      issued_all_q  <= issued_all_d;
      pend_q        <= pend_d;
      pend_idx_q    <= pend_idx_d;
      last_idx_q    <= last_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      valid_q       <= valid_d;
      occ_q         <= occ_d;
      for (int i = 0; i < 3; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
        lst_q[i]  <= lst_d[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rom_enable_d  = 1'b0;
    rom_address_d = rom_address_q;
    next_idx_d    = next_idx_q;
    issued_all_d  = issued_all_q;
    pend_d        = rom_enable_q;
    pend_idx_d    = rom_address_q;
    last_idx_d    = last_idx_q;
    busy_d        = busy_q;
    done_d        = done_q;
    valid_d       = valid_q;
    occ_d         = occ_q;
    data_d        = data_q;
    tag_d         = tag_q;
    lst_d         = lst_q;
    pop           = valid_q & angle_ready;
    occ_t         = occ_q;
    unique case (state_q)
      P_IDLE: begin
        if (start) begin
          state_d       = P_RUN;
          rom_enable_d  = 1'b1;
          rom_address_d = '0;
          next_idx_d    = 5'd1;
          issued_all_d  = (n_iter == 5'd0);
          last_idx_d    = n_iter;
          busy_d        = 1'b1;
        end
      end
      P_RUN: begin
        if (pop) begin
          for (int i = 0; i < 2; i++) begin
            data_d[i] = data_q[i+1];
            tag_d[i]  = tag_q[i+1];
            lst_d[i]  = lst_q[i+1];
          end
          occ_t = occ_q - 2'd1;
        end
        // Slot 0 is the registered output; arrivals land behind survivors.
        if (pend_q) begin
          data_d[occ_t] = rom_data;
          tag_d[occ_t]  = pend_idx_q;
          lst_d[occ_t]  = (pend_idx_q == last_idx_q);
          occ_t         = occ_t + 2'd1;
        end
        occ_d   = occ_t;
        valid_d = (occ_t != 2'd0);
        if (!issued_all_q &&
            (({1'b0, occ_t} + {2'b0, rom_enable_q}) < 3'd3)) begin
          rom_enable_d  = 1'b1;
          rom_address_d = next_idx_q;
          next_idx_d    = next_idx_q + 5'd1;
          issued_all_d  = (next_idx_q == last_idx_q);
        end
        if (pop && lst_q[0]) begin
          done_d  = 1'b1;
          valid_d = 1'b0;
          occ_d   = '0;
          state_d = P_DONE;
        end
      end
      P_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = P_IDLE;
      end
      default: state_d = P_IDLE;
    endcase
  end

  assign rom_enable  = rom_enable_q;
  assign rom_address = rom_address_q;
  assign angle_valid = valid_q;
  assign angle_data  = data_q[0];
  assign angle_index = tag_q[0];
  assign angle_last  = lst_q[0];
  assign busy        = busy_q;
  assign done        = done_q;

`else

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_OFFER,
    S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic         rom_enable_q, rom_enable_d;
  logic [4:0]   rom_address_q, rom_address_d;
  logic [4:0]   idx_q, idx_d;
  logic [4:0]   last_idx_q, last_idx_d;
  logic         angle_valid_q, angle_valid_d;
  logic [W-1:0] angle_data_q, angle_data_d;
  logic [4:0]   angle_index_q, angle_index_d;
  logic         angle_last_q, angle_last_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rom_enable_q  <= 1'b0;
      rom_address_q <= '0;
      idx_q         <= '0;
      last_idx_q    <= '0;
      angle_valid_q <= 1'b0;
      angle_data_q  <= '0;
      angle_index_q <= '0;
      angle_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_enable_q  <= rom_enable_d;
      rom_address_q <= rom_address_d;
      idx_q         <= idx_d;
      last_idx_q    <= last_idx_d;
      angle_valid_q <= angle_valid_d;
      angle_data_q  <= angle_data_d;
      angle_index_q <= angle_index_d;
      angle_last_q  <= angle_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rom_enable_d  = rom_enable_q;
    rom_address_d = rom_address_q;
    idx_d         = idx_q;
    last_idx_d    = last_idx_q;
    angle_valid_d = angle_valid_q;
    angle_data_d  = angle_data_q;
    angle_index_d = angle_index_q;
    angle_last_d  = angle_last_q;
    busy_d        = busy_q;
    done_d        = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_REQ;
          rom_enable_d  = 1'b1;
          rom_address_d = '0;
          idx_d         = '0;
          last_idx_d    = n_iter;
          busy_d        = 1'b1;
        end
      end
      S_REQ: begin
        rom_enable_d = 1'b0;
        state_d      = S_CAP;
      end
      S_CAP: begin
        angle_data_d  = rom_data;
        angle_index_d = idx_q;
        angle_last_d  = (idx_q == last_idx_q);
        angle_valid_d = 1'b1;
        state_d       = S_OFFER;
      end
      S_OFFER: begin
        if (angle_ready) begin
          angle_valid_d = 1'b0;
          if (angle_last_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d         = idx_q + 5'd1;
            rom_enable_d  = 1'b1;
            rom_address_d = idx_q + 5'd1;
            state_d       = S_REQ;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_enable  = rom_enable_q;
  assign rom_address = rom_address_q;
  assign angle_valid = angle_valid_q;
  assign angle_data  = angle_data_q;
  assign angle_index = angle_index_q;
  assign angle_last  = angle_last_q;
  assign busy        = busy_q;
  assign done        = done_q;

`endif

endmodule
